clk_tick_meter: RTL and testbench

- Receiving end of the clock-divider outputs.
- Samples one slow divided clock (0.5 Hz–1 kHz class signals such as clk_clock, clk_car or clk) in the clk_100m domain.
- Produces a one-cycle rising-edge enable, measures the rising-to-rising period in clk_100m cycles, and flags out-of-range or stopped clocks.
- Used by the clock/car-timing logic instead of clocking flops from divided clocks.

---
 rtl/clk_tick_meter_pkg.sv | 24 ++
 rtl/clk_tick_meter_sync_edge.sv | 39 +++
 rtl/clk_tick_meter.sv | 178 +++++++++++++++++
 tb/tb_clk_tick_meter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_tick_meter_pkg.sv
// ============================================================================
// Package     : clk_tick_pkg
// Description : Shared state encoding and default divided-clock periods for
//               clk_tick_meter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_tick_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LOST = 2'd2
    } state_e;

    // Nominal periods of the divider outputs, in 100 MHz cycles.
    localparam int unsigned C_PERIOD_1HZ   = 100_000_000;
    localparam int unsigned C_PERIOD_0HZ5  = 200_000_000;
    localparam int unsigned C_PERIOD_1KHZ  = 100_000;

endpackage

`default_nettype wire

// File: rtl/clk_tick_meter_sync_edge.sv
// ============================================================================
// Module      : sync_edge
// Description : Multi-flop synchronizer plus delay flop; flags rising and
//               falling edges of an asynchronous slow clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~dly_q;
    assign fall_o = ~sync_o & dly_q;

endmodule

`default_nettype wire

// File: rtl/clk_tick_meter.sv
// ============================================================================
// Module      : clk_tick_meter
// Description : Rising-edge enable, period measurement and loss detection for
//               a slow divided clock. Macro CLK_TICK_METER_DUTY_EN adds
//               high-phase measurement on high_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_tick_meter
    import clk_tick_pkg::*;
#(
    parameter int          CNT_W       = 32,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = C_PERIOD_1HZ,
    parameter int unsigned PERIOD_MIN  = 99_000_000,
    parameter int unsigned PERIOD_MAX  = 101_000_000
) (
    input  logic             clk_100m,
    input  logic             reset,
    input  logic             sig_in,
    output logic             rise_pulse,
    output logic [CNT_W-1:0] period_cnt,
    output logic             period_valid,
    output logic             in_range,
    output logic             lost,
    output logic [CNT_W-1:0] high_cnt
);

    localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] C_MIN     = CNT_W'(PERIOD_MIN);
    localparam logic [CNT_W-1:0] C_MAX     = CNT_W'(PERIOD_MAX);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_SAT     = '1;

    logic w_sync, w_rise, w_fall;

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_i  (clk_100m),
        .rst_ni (reset),
        .sig_i  (sig_in),
        .sync_o (w_sync),
        .rise_o (w_rise),
        .fall_o (w_fall)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             rise_q;
    logic             valid_q, valid_d;
    logic             in_range_q, in_range_d;
    logic             lost_q, lost_d;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_high_report;

    assign w_cnt_inc = (cnt_q == C_SAT) ? cnt_q : cnt_q + C_ONE;

`ifdef CLK_TICK_METER_DUTY_EN
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] hi_hold_q, hi_hold_d;
    logic             fall_seen_q, fall_seen_d;

    always_comb begin
        hi_cnt_d    = hi_cnt_q;
        hi_hold_d   = hi_hold_q;
        fall_seen_d = fall_seen_q;
        if (w_rise) begin
            hi_cnt_d    = C_ONE;
            fall_seen_d = 1'b0;
        end else if (w_sync && (hi_cnt_q != C_SAT)) begin
            hi_cnt_d = hi_cnt_q + C_ONE;
        end
        if (w_fall) begin
            hi_hold_d   = hi_cnt_q;
            fall_seen_d = 1'b1;
        end
    end

    always_ff @(posedge clk_100m or negedge reset) begin
        if (!reset) begin
            hi_cnt_q    <= '0;
            hi_hold_q   <= '0;
            fall_seen_q <= 1'b0;
        end else begin
            hi_cnt_q    <= hi_cnt_d;
            hi_hold_q   <= hi_hold_d;
            fall_seen_q <= fall_seen_d;
        end
    end

    // Without a fall since the last rise the whole period was high.
    assign w_high_report = fall_seen_q ? hi_hold_q : hi_cnt_q;
`else
    logic w_unused_duty;
    assign w_unused_duty = ^{w_sync, w_fall};
    assign w_high_report = '0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = w_cnt_inc;
        period_d   = period_q;
        high_d     = high_q;
        valid_d    = 1'b0;
        in_range_d = in_range_q;
        lost_d     = lost_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (w_rise) begin
                    state_d = S_RUN;
                    cnt_d   = C_ONE;
                end
            end
            S_RUN: begin
                // A rise landing on the timeout cycle still counts as a period.
                if (w_rise) begin
                    period_d   = cnt_q;
                    high_d     = w_high_report;
                    valid_d    = 1'b1;
                    in_range_d = (cnt_q >= C_MIN) && (cnt_q <= C_MAX);
                    cnt_d      = C_ONE;
                end else if (cnt_q == C_TIMEOUT) begin
                    state_d    = S_LOST;
                    lost_d     = 1'b1;
                    in_range_d = 1'b0;
                end
            end
            S_LOST: begin
                if (w_rise) begin
                    state_d = S_RUN;
                    lost_d  = 1'b0;
                    cnt_d   = C_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_100m or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            high_q     <= '0;
            rise_q     <= 1'b0;
            valid_q    <= 1'b0;
            in_range_q <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            high_q     <= high_d;
            rise_q     <= w_rise;
            valid_q    <= valid_d;
            in_range_q <= in_range_d;
            lost_q     <= lost_d;
        end
    end

    assign rise_pulse   = rise_q;
    assign period_cnt   = period_q;
    assign period_valid = valid_q;
    assign in_range     = in_range_q;
    assign lost         = lost_q;
    assign high_cnt     = high_q;

endmodule

`default_nettype wire

// File: tb/tb_clk_tick_meter.sv
// ============================================================================
// Module      : tb_clk_tick_meter
// Description : Scoreboard bench for clk_tick_meter; honours
//               CLK_TICK_METER_DUTY_EN for the high_cnt expectations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_tick_meter;

    localparam int          CNT_W       = 32;
    localparam int          SYNC_STAGES = 2;
    localparam int unsigned TIMEOUT_CYC = 5000;
    localparam int unsigned PERIOD_MIN  = 900;
    localparam int unsigned PERIOD_MAX  = 1100;

    logic             clk_100m = 1'b0;
    logic             reset    = 1'b0;
    logic             sig_in   = 1'b0;
    logic             rise_pulse;
    logic [CNT_W-1:0] period_cnt;
    logic             period_valid;
    logic             in_range;
    logic             lost;
    logic [CNT_W-1:0] high_cnt;

    clk_tick_meter #(
        .CNT_W       (CNT_W),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .PERIOD_MIN  (PERIOD_MIN),
        .PERIOD_MAX  (PERIOD_MAX)
    ) u_dut (
        .clk_100m     (clk_100m),
        .reset        (reset),
        .sig_in       (sig_in),
        .rise_pulse   (rise_pulse),
        .period_cnt   (period_cnt),
        .period_valid (period_valid),
        .in_range     (in_range),
        .lost         (lost),
        .high_cnt     (high_cnt)
    );

    always #5 clk_100m = ~clk_100m;

    int cyc = 0;
    always @(posedge clk_100m) cyc <= cyc + 1;

    typedef struct {
        int          drv_cyc;
        logic        pv;
        logic [31:0] per;
        logic        ir;
        logic [31:0] hi;
    } exp_t;

    exp_t q[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state, driven purely from stimulus timing.
    bit          started   = 1'b0;
    int          last_rise = 0;
    logic [31:0] exp_per   = '0;
    logic [31:0] exp_hi    = '0;
    logic [31:0] last_hi   = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        started = 1'b0;
        exp_per = '0;
        exp_hi  = '0;
        last_hi = '0;
    endtask

    task automatic push_rise();
        exp_t e;
        int   gap;
        gap       = cyc - last_rise;
        e.drv_cyc = cyc;
        e.pv      = started && (gap <= int'(TIMEOUT_CYC));
        if (e.pv) begin
            exp_per = gap;
`ifdef CLK_TICK_METER_DUTY_EN
            exp_hi  = last_hi;
`endif
        end
        e.per = exp_per;
        e.hi  = exp_hi;
        e.ir  = e.pv && (gap >= int'(PERIOD_MIN)) && (gap <= int'(PERIOD_MAX));
        q.push_back(e);
        started   = 1'b1;
        last_rise = cyc;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_100m);
        #1;
    endtask

    task automatic drive_cycle(input int per, input int hi);
        sig_in = 1'b1;
        push_rise();
        wait_cyc(hi);
        sig_in  = 1'b0;
        last_hi = cyc - last_rise;
        wait_cyc(per - hi);
    endtask

    task automatic check_cleared(input string tag);
        check_eq({tag, "_rise"},   rise_pulse,   0);
        check_eq({tag, "_pv"},     period_valid, 0);
        check_eq({tag, "_period"}, period_cnt,   0);
        check_eq({tag, "_inr"},    in_range,     0);
        check_eq({tag, "_lost"},   lost,         0);
        check_eq({tag, "_high"},   high_cnt,     0);
    endtask

    always @(negedge clk_100m) begin
        exp_t e;
        if (rise_pulse) begin
            check_eq("sb_nonempty", q.size() > 0, 1);
            if (q.size() > 0) begin
                e = q.pop_front();
                check_eq("rise_lat", cyc - e.drv_cyc, SYNC_STAGES + 1);
                check_eq("pv",       period_valid, e.pv);
                check_eq("period",   period_cnt,   e.per);
                check_eq("in_range", in_range,     e.ir);
                check_eq("lost_clr", lost,         0);
                check_eq("high",     high_cnt,     e.hi);
            end
        end
        if (period_valid) check_eq("pv_align", rise_pulse, 1);
    end

    initial begin
        int t_loss;
        wait_cyc(5);
        reset = 1'b1;
        wait_cyc(100);
        check_cleared("reset");

        repeat (5) drive_cycle(1000, 500);
        repeat (2) drive_cycle(1200, 600);
        repeat (3) drive_cycle(1000, 500);

        // Loss: one rise, then hold low until the meter gives up.
        sig_in = 1'b1;
        push_rise();
        t_loss = cyc;
        wait_cyc(500);
        sig_in  = 1'b0;
        last_hi = cyc - last_rise;
        for (int i = 0; i < int'(TIMEOUT_CYC) + 1000 && !lost; i++) @(negedge clk_100m);
        check_eq("lost_seen",   lost, 1);
        check_eq("lost_lat",    cyc - t_loss, TIMEOUT_CYC + 3);
        check_eq("lost_inr",    in_range, 0);
        check_eq("lost_period", period_cnt, exp_per);
        @(posedge clk_100m);
        #1;
        repeat (3) drive_cycle(1000, 500);

        // Rise spacing equal to the timeout is still a valid period.
        drive_cycle(TIMEOUT_CYC, 500);
        check_eq("bnd_lost_hold", lost, 0);
        repeat (2) drive_cycle(1000, 500);
        check_eq("bnd_lost_after", lost, 0);

        // Asynchronous reset in the middle of a measured cycle.
        drive_cycle(1000, 500);
        sig_in = 1'b1;
        push_rise();
        wait_cyc(200);
        check_eq("pre_rst_inr", in_range, 1);
        sig_in = 1'b0;
        reset  = 1'b0;
        #1;
        check_cleared("midrst");
        model_reset();
        wait_cyc(3);
        reset = 1'b1;
        wait_cyc(10);
        repeat (3) drive_cycle(1000, 500);

        wait_cyc(20);
        check_eq("sb_empty", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
